// File: rtl/usb_txn_arb.sv
// rtl/usb_txn_arb.sv - USB transaction arbiter granting one requester at a time the shared SIE transmit path
//
// Ports:
//   c              bus clock
//   rst_n          asynchronous active-low reset
//   sof            one-cycle start-of-frame pulse
//   req[2:0]       transaction requests (0 = enumeration/control, 1-2 = endpoint pollers)
//   rq_done[2:0]   per-requester transaction-complete pulse
//   rq_token_d     three 19-bit token words, requester i at [19i+18:19i]
//   rq_token_start per-requester token start
//   rq_data_d      three data bytes, requester i at [8i+7:8i]
//   rq_data_dv     per-requester data valid
//   rq_ack_start   per-requester ack start
//   gnt[2:0]       one-hot registered grant
//   token_d, token_start, data_d, data_dv, ack_start
//                  shared SIE transmit path, driven by the granted requester, zero when idle
//   busy           a grant is held
//   err_timeout    sticky: a grant was revoked because it was held too long
`timescale 1ns/1ps
module usb_txn_arb #(
    parameter logic [16:0] FRAME_CYC   = 17'd100000,
    parameter logic [16:0] GUARD_CYC   = 17'd10000,
    parameter logic [16:0] TIMEOUT_CYC = 17'd50000
) (
    input  logic        c,
    input  logic        rst_n,
    input  logic        sof,
    input  logic [2:0]  req,
    input  logic [2:0]  rq_done,
    input  logic [56:0] rq_token_d,
    input  logic [2:0]  rq_token_start,
    input  logic [23:0] rq_data_d,
    input  logic [2:0]  rq_data_dv,
    input  logic [2:0]  rq_ack_start,
    output logic [2:0]  gnt,
    output logic [18:0] token_d,
    output logic        token_start,
    output logic [7:0]  data_d,
    output logic        data_dv,
    output logic        ack_start,
    output logic        busy,
    output logic        err_timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [16:0] OPEN_LIM = FRAME_CYC - GUARD_CYC;
    localparam logic [16:0] FCNT_MAX = 17'h1FFFF;

    state_t      state_q, state_d;
    logic [2:0]  gnt_q, gnt_d;
    logic        lp_q, lp_d;        // last served poller: 0 = requester 1, 1 = requester 2
    logic [16:0] hold_q, hold_d;
    logic [16:0] fcnt_q, fcnt_d;
    logic        err_q, err_d;

    logic [2:0]  pick;
    logic        window_open;
    logic        done_g;
    logic        timeout_hit;

    assign window_open = (fcnt_q < OPEN_LIM);
    assign done_g      = |(rq_done & gnt_q);
    assign timeout_hit = (hold_q == TIMEOUT_CYC - 17'd1);

    // Control requester always wins; pollers alternate when both ask.
    always_comb begin
        pick = 3'b000;
        if (req[0]) begin
            pick = 3'b001;
        end else if (req[1] && req[2]) begin
            pick = lp_q ? 3'b010 : 3'b100;
        end else if (req[1]) begin
            pick = 3'b010;
        end else if (req[2]) begin
            pick = 3'b100;
        end
    end

    // Frame counter saturates so the window stays closed until the first sof.
    always_comb begin
        fcnt_d = fcnt_q;
        if (sof) begin
            fcnt_d = 17'd0;
        end else if (fcnt_q != FCNT_MAX) begin
            fcnt_d = fcnt_q + 17'd1;
        end
    end

    // GAP arbitrates like IDLE so exactly one zero-grant cycle separates grants.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        lp_d    = lp_q;
        hold_d  = hold_q;
        err_d   = err_q;
        case (state_q)
            IDLE, GAP: begin
                state_d = IDLE;
                gnt_d   = 3'b000;
                if (window_open && (req != 3'b000)) begin
                    state_d = BUSY;
                    gnt_d   = pick;
                    hold_d  = 17'd0;
                    if (!pick[0]) begin
                        lp_d = pick[2];
                    end
                end
            end
            BUSY: begin
                if (done_g) begin
                    state_d = GAP;
                    gnt_d   = 3'b000;
                end else if (timeout_hit) begin
                    state_d = GAP;
                    gnt_d   = 3'b000;
                    err_d   = 1'b1;
                end else begin
                    hold_d = hold_q + 17'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 3'b000;
            end
        endcase
    end

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 3'b000;
            lp_q    <= 1'b1;
            hold_q  <= 17'd0;
            fcnt_q  <= FCNT_MAX;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            lp_q    <= lp_d;
            hold_q  <= hold_d;
            fcnt_q  <= fcnt_d;
            err_q   <= err_d;
        end
    end

    // Shared transmit path follows the registered grant; all zero when nothing is granted.
    always_comb begin
        token_d     = 19'd0;
        token_start = 1'b0;
        data_d      = 8'd0;
        data_dv     = 1'b0;
        ack_start   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (gnt_q[i]) begin
                token_d     = rq_token_d[19*i +: 19];
                token_start = rq_token_start[i];
                data_d      = rq_data_d[8*i +: 8];
                data_dv     = rq_data_dv[i];
                ack_start   = rq_ack_start[i];
            end
        end
    end

    assign gnt         = gnt_q;
    assign busy        = |gnt_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_usb_txn_arb.sv
// tb/tb_usb_txn_arb.sv - self-checking bench for usb_txn_arb
`timescale 1ns/1ps
module tb_usb_txn_arb;

    localparam logic [16:0] F = 17'd2000;
    localparam logic [16:0] G = 17'd200;
    localparam logic [16:0] T = 17'd500;
    localparam int OPEN_LIM = int'(F) - int'(G);
    localparam int TO       = int'(T);

    logic        c;
    logic        rst_n;
    logic        sof;
    logic [2:0]  req;
    logic [2:0]  rq_done;
    logic [56:0] rq_token_d;
    logic [2:0]  rq_token_start;
    logic [23:0] rq_data_d;
    logic [2:0]  rq_data_dv;
    logic [2:0]  rq_ack_start;
    logic [2:0]  gnt;
    logic [18:0] token_d;
    logic        token_start;
    logic [7:0]  data_d;
    logic        data_dv;
    logic        ack_start;
    logic        busy;
    logic        err_timeout;

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the bus, for how long, where the frame is.
    int m_fcnt;
    int m_own;
    int m_held;
    int m_last;
    bit m_err;

    usb_txn_arb #(
        .FRAME_CYC  (F),
        .GUARD_CYC  (G),
        .TIMEOUT_CYC(T)
    ) dut (
        .c             (c),
        .rst_n         (rst_n),
        .sof           (sof),
        .req           (req),
        .rq_done       (rq_done),
        .rq_token_d    (rq_token_d),
        .rq_token_start(rq_token_start),
        .rq_data_d     (rq_data_d),
        .rq_data_dv    (rq_data_dv),
        .rq_ack_start  (rq_ack_start),
        .gnt           (gnt),
        .token_d       (token_d),
        .token_start   (token_start),
        .data_d        (data_d),
        .data_dv       (data_dv),
        .ack_start     (ack_start),
        .busy          (busy),
        .err_timeout   (err_timeout)
    );

    initial c = 1'b0;
    always #5 c = ~c;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_fcnt = 131071;
        m_own  = -1;
        m_held = 0;
        m_last = 2;
        m_err  = 1'b0;
    endfunction

    function automatic int model_pick(input logic [2:0] r);
        if (r[0]) return 0;
        if (r[1] && r[2]) return (m_last == 1) ? 2 : 1;
        if (r[1]) return 1;
        return 2;
    endfunction

    function automatic void model_step();
        bit open;
        open = (m_fcnt < OPEN_LIM);
        if (m_own >= 0) begin
            if (rq_done[m_own]) begin
                m_own = -1;
            end else if (m_held == TO - 1) begin
                m_own = -1;
                m_err = 1'b1;
            end else begin
                m_held++;
            end
        end else if (open && req != 3'b000) begin
            m_own  = model_pick(req);
            m_held = 0;
            if (m_own != 0) m_last = m_own;
        end
        if (sof) m_fcnt = 0;
        else if (m_fcnt < 131071) m_fcnt++;
    endfunction

    task automatic compare_all();
        logic [2:0] eg;
        eg = (m_own < 0) ? 3'b000 : 3'(1 << m_own);
        check("gnt", gnt, eg);
        check("busy", busy, (m_own >= 0));
        check("err_timeout", err_timeout, m_err);
        check("token_d", token_d, (m_own < 0) ? 19'd0 : rq_token_d[19*m_own +: 19]);
        check("token_start", token_start, (m_own < 0) ? 1'b0 : rq_token_start[m_own]);
        check("data_d", data_d, (m_own < 0) ? 8'd0 : rq_data_d[8*m_own +: 8]);
        check("data_dv", data_dv, (m_own < 0) ? 1'b0 : rq_data_dv[m_own]);
        check("ack_start", ack_start, (m_own < 0) ? 1'b0 : rq_ack_start[m_own]);
    endtask

    // Inputs are set at the falling edge; outputs are compared just after, then the model steps on the rising edge.
    task automatic tick();
        #1 compare_all();
        @(posedge c);
        if (rst_n) model_step();
        @(negedge c);
    endtask

    task automatic rand_side();
        rq_token_d     = 57'({$urandom(), $urandom()});
        rq_token_start = 3'($urandom());
        rq_data_d      = 24'($urandom());
        rq_data_dv     = 3'($urandom());
        rq_ack_start   = 3'($urandom());
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] rr_exp [4];
        int n;
        rr_exp = '{3'b010, 3'b100, 3'b010, 3'b100};

        rst_n = 1'b0; sof = 1'b0; req = 3'b000; rq_done = 3'b000;
        rq_token_d = '0; rq_token_start = '0; rq_data_d = '0; rq_data_dv = '0; rq_ack_start = '0;
        model_reset();
        @(negedge c);
        tick();
        check("rst_gnt", gnt, 3'b000);
        check("rst_err", err_timeout, 1'b0);

        // No grant before the first sof even with all requesting.
        rst_n = 1'b1;
        req = 3'b111;
        repeat (20) tick();
        check("no_sof_gnt", gnt, 3'b000);
        sof = 1'b1; tick();
        sof = 1'b0; tick();
        check("sof_gnt", gnt, 3'b001);
        rq_done = 3'b001; tick();
        rq_done = 3'b000;

        // Pollers alternate with exactly one idle cycle between grants.
        req = 3'b110;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rr_seq", gnt, rr_exp[k]);
            rq_done = gnt; tick();
            rq_done = 3'b000;
            check("rr_gap", gnt, 3'b000);
        end
        req = 3'b000; tick();

        // Routing of the granted requester only.
        req = 3'b010; tick();
        check("tok_gnt", gnt, 3'b010);
        rq_token_d = {19'h7ABCD, 19'h12345, 19'h0F0F0};
        rq_token_start = 3'b010;
        #1;
        check("tok_d", token_d, 19'h12345);
        check("tok_start", token_start, 1'b1);
        rq_token_start = 3'b101;
        #1;
        check("tok_start_other", token_start, 1'b0);
        rq_done = 3'b010; tick();
        rq_done = 3'b000; req = 3'b000; rq_token_start = 3'b000; tick();

        // Forced revoke after TIMEOUT cycles; foreign done and req drop ignored.
        sof = 1'b1; tick();
        sof = 1'b0; req = 3'b100; tick();
        check("to_gnt", gnt, 3'b100);
        req = 3'b000; rq_done = 3'b011;
        n = 1;
        for (int w = 0; w < TO + 10 && gnt != 3'b000; w++) begin
            tick();
            if (gnt != 3'b000) n++;
        end
        check("to_len", n, TO);
        check("to_err", err_timeout, 1'b1);
        rq_done = 3'b000;
        repeat (5) tick();
        check("to_sticky", err_timeout, 1'b1);

        // Completion in the timeout cycle wins: no error.
        rst_n = 1'b0; model_reset(); tick();
        rst_n = 1'b1;
        sof = 1'b1; tick();
        sof = 1'b0; req = 3'b001; tick();
        check("race_gnt", gnt, 3'b001);
        repeat (TO - 1) tick();
        rq_done = 3'b001; tick();
        rq_done = 3'b000; req = 3'b000;
        check("race_err", err_timeout, 1'b0);
        check("race_gnt_off", gnt, 3'b000);

        // Request arriving in the guard window waits for the next sof.
        for (int w = 0; w < 4000 && m_fcnt < OPEN_LIM; w++) tick();
        req = 3'b001;
        repeat (50) tick();
        check("win_closed", gnt, 3'b000);
        sof = 1'b1; tick();
        sof = 1'b0; tick();
        check("win_sof", gnt, 3'b001);

        // Asynchronous reset in the middle of a grant.
        rq_data_dv = 3'b001;
        #1;
        check("pre_dv", data_dv, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_gnt", gnt, 3'b000);
        check("async_dv", data_dv, 1'b0);
        check("async_busy", busy, 1'b0);
        model_reset();
        @(negedge c);
        req = 3'b000; rq_data_dv = 3'b000;
        tick();
        rst_n = 1'b1;

        // Randomized traffic against the model.
        sof = 1'b1; tick();
        for (int i = 0; i < 3000; i++) begin
            sof     = ($urandom_range(0, 299) == 0);
            req     = 3'($urandom());
            rq_done = 3'($urandom()) & 3'($urandom()) & 3'($urandom());
            rand_side();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
